// File: rtl/rr_stream_mux_if.sv
// Handshake bundle for the N:1 round-robin stream mux.
// Producer side drives in_* and out_ready; the mux side is the slave modport.
interface rr_stream_mux_if #(
   parameter int N_CH = 4,
   parameter int W    = 8
);
   localparam int CH_W = $clog2(N_CH);

   logic [N_CH-1:0]   in_valid;
   logic [N_CH*W-1:0] in_data;
   logic [N_CH-1:0]   in_ready;
   logic              out_valid;
   logic [W-1:0]      out_data;
   logic [CH_W-1:0]   out_ch;
   logic              out_ready;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_ch
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_ch
   );
endinterface

// File: rtl/rr_stream_mux.sv
// Round-robin N:1 stream mux with one registered output stage; 1-cycle latency.
// Backpressure: while a held word is stalled by out_ready=0, every in_ready is low.
module rr_stream_mux #(
   parameter int  N_CH = 4,
   parameter int  W    = 8,
   localparam int CH_W = $clog2(N_CH)
) (
   input  logic           clk,
   input  logic           rst,
   rr_stream_mux_if.slave bus
);
   logic [CH_W-1:0] ptr;
   logic [CH_W-1:0] grant;
   logic [CH_W-1:0] ptr_nxt;
   logic [N_CH-1:0] hi_mask;
   logic [N_CH-1:0] masked;
   logic [N_CH-1:0] ready_c;
   logic [W-1:0]    grant_data;
   logic            found;
   logic            load;
   logic            xfer_in;
   logic            xfer_out;

   logic            ov_q;
   logic [W-1:0]    od_q;
   logic [CH_W-1:0] och_q;

   assign load     = !ov_q || bus.out_ready;
   assign found    = |bus.in_valid;
   assign xfer_out = ov_q && bus.out_ready;

   // Lowest valid channel at or above ptr wins; otherwise wrap to lowest valid overall.
   always_comb begin
      hi_mask = '0;
      for (int i = 0; i < N_CH; i++) begin
         hi_mask[i] = (i >= int'(ptr));
      end
      masked = bus.in_valid & hi_mask;
      grant  = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (bus.in_valid[i]) grant = i[CH_W-1:0];
      end
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (masked[i]) grant = i[CH_W-1:0];
      end
   end

   always_comb begin
      grant_data = '0;
      ready_c    = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (grant == i[CH_W-1:0]) begin
            grant_data = bus.in_data[i*W +: W];
            ready_c[i] = found && load && !rst;
         end
      end
   end

   assign xfer_in = |(ready_c & bus.in_valid);
   assign ptr_nxt = (int'(grant) == N_CH - 1) ? '0 : grant + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         ov_q  <= 1'b0;
         od_q  <= '0;
         och_q <= '0;
         ptr   <= '0;
      end else if (xfer_in) begin
         ov_q  <= 1'b1;
         od_q  <= grant_data;
         och_q <= grant;
         ptr   <= ptr_nxt;
      end else if (xfer_out) begin
         ov_q  <= 1'b0;
      end
   end

   assign bus.in_ready  = ready_c;
   assign bus.out_valid = ov_q;
   assign bus.out_data  = od_q;
   assign bus.out_ch    = och_q;
endmodule
